// File: rtl/i2c_target_frontend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_frontend_pkg
// Purpose  : Shared constants, FSM encoding and helpers for the I2C target.
// Revision : 1.0
// ============================================================================
package i2c_target_frontend_pkg;

    localparam logic [6:0] C_DEVICE_ADDR = 7'h2A;

    // Gain register addresses, shared with the register file
    localparam logic [7:0] C_KP_ADDR = 8'h40;
    localparam logic [7:0] C_KI_ADDR = 8'h41;
    localparam logic [7:0] C_KD_ADDR = 8'h42;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RD_FETCH  = 4'd7,
        ST_RDATA     = 4'd8,
        ST_RDATA_ACK = 4'd9,
        ST_IGNORE    = 4'd10
    } state_t;

    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] dev);
        return addr_byte[7:1] == dev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_target_frontend_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_frontend_if
// Purpose  : Register-access strobe bus between the I2C target and gain file.
// Revision : 1.0
// ============================================================================
interface i2c_target_frontend_if;
    logic [7:0] reg_addr;
    logic [5:0] update_value;
    logic       read_or_write;
    logic       ena;
    logic [7:0] read_value;

    modport master (
        output reg_addr, update_value, read_or_write, ena,
        input  read_value
    );

    modport slave (
        input  reg_addr, update_value, read_or_write, ena,
        output read_value
    );
endinterface
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : i2c_sync_edge
// Purpose  : SCL/SDA synchronisers with SCL edge and START/STOP detection.
// Revision : 1.0
// ============================================================================
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    // Reset to the idle-bus level so leaving reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl     = r_scl_sync[SYNC_STAGES-1];
    assign w_sda     = r_sda_sync[SYNC_STAGES-1];
    assign sda_sync  = w_sda;
    assign scl_rise  = w_scl & ~r_scl_d;
    assign scl_fall  = ~w_scl & r_scl_d;
    assign start_det = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign stop_det  = w_scl & r_scl_d & ~r_sda_d & w_sda;
endmodule
`default_nettype wire

// File: rtl/i2c_target_frontend.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_frontend
// Purpose  : I2C target decoding transfers into register read/write strobes.
// Revision : 1.0
// ============================================================================
module i2c_target_frontend
    import i2c_target_frontend_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = C_DEVICE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scl_in,
    input  logic                         sda_in,
    output logic                         sda_oe,
    output logic                         busy,
    i2c_target_frontend_if.master        regs
);
    logic w_sda, w_rise, w_fall, w_start, w_stop;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_sync  (w_sda),
        .scl_rise  (w_rise),
        .scl_fall  (w_fall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    state_t     r_state, w_state;
    logic [3:0] r_bit_cnt, w_bit_cnt;
    logic [1:0] r_fetch_cnt, w_fetch_cnt;
    logic [7:0] r_shift, w_shift;
    logic [7:0] r_tx, w_tx;
    logic [7:0] r_ptr, w_ptr;
    logic [7:0] r_reg_addr, w_reg_addr;
    logic [5:0] r_update_value, w_update_value;
    logic       r_rw_bit, w_rw_bit;
    logic       r_sda_oe, w_sda_oe;
    logic       r_busy, w_busy;
    logic       r_ena, w_ena;
    logic       r_read_or_write, w_read_or_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_bit_cnt       <= '0;
            r_fetch_cnt     <= '0;
            r_shift         <= '0;
            r_tx            <= '0;
            r_ptr           <= '0;
            r_reg_addr      <= '0;
            r_update_value  <= '0;
            r_rw_bit        <= 1'b0;
            r_sda_oe        <= 1'b0;
            r_busy          <= 1'b0;
            r_ena           <= 1'b0;
            r_read_or_write <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_bit_cnt       <= w_bit_cnt;
            r_fetch_cnt     <= w_fetch_cnt;
            r_shift         <= w_shift;
            r_tx            <= w_tx;
            r_ptr           <= w_ptr;
            r_reg_addr      <= w_reg_addr;
            r_update_value  <= w_update_value;
            r_rw_bit        <= w_rw_bit;
            r_sda_oe        <= w_sda_oe;
            r_busy          <= w_busy;
            r_ena           <= w_ena;
            r_read_or_write <= w_read_or_write;
        end
    end

    always_comb begin
        w_state         = r_state;
        w_bit_cnt       = r_bit_cnt;
        w_fetch_cnt     = r_fetch_cnt;
        w_shift         = r_shift;
        w_tx            = r_tx;
        w_ptr           = r_ptr;
        w_reg_addr      = r_reg_addr;
        w_update_value  = r_update_value;
        w_rw_bit        = r_rw_bit;
        w_sda_oe        = r_sda_oe;
        w_busy          = r_busy;
        w_ena           = 1'b0;
        w_read_or_write = r_read_or_write;

        if (w_rise) begin
            w_shift   = {r_shift[6:0], w_sda};
            w_bit_cnt = r_bit_cnt + 4'd1;
        end

        if (w_start) begin
            w_state     = ST_ADDR;
            w_bit_cnt   = '0;
            w_fetch_cnt = '0;
            w_sda_oe    = 1'b0;
        end else if (w_stop) begin
            w_state   = ST_IDLE;
            w_bit_cnt = '0;
            w_sda_oe  = 1'b0;
            w_busy    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: if (w_fall && r_bit_cnt == 4'd8) begin
                    w_bit_cnt = '0;
                    if (addr_hit(r_shift, DEVICE_ADDR)) begin
                        w_state  = ST_ADDR_ACK;
                        w_sda_oe = 1'b1;
                        w_busy   = 1'b1;
                        w_rw_bit = r_shift[0];
                    end else begin
                        w_state = ST_IGNORE;
                        w_busy  = 1'b0;
                    end
                end
                ST_ADDR_ACK: if (w_fall) begin
                    w_bit_cnt   = '0;
                    w_fetch_cnt = '0;
                    w_sda_oe    = 1'b0;
                    w_state     = r_rw_bit ? ST_RD_FETCH : ST_PTR;
                end
                ST_PTR: if (w_fall && r_bit_cnt == 4'd8) begin
                    w_bit_cnt = '0;
                    w_ptr     = r_shift;
                    w_sda_oe  = 1'b1;
                    w_state   = ST_PTR_ACK;
                end
                ST_PTR_ACK, ST_WDATA_ACK: if (w_fall) begin
                    w_bit_cnt = '0;
                    w_sda_oe  = 1'b0;
                    w_state   = ST_WDATA;
                end
                ST_WDATA: begin
                    // Strobe as soon as the last bit is sampled; bits [7:6] are dropped
                    if (w_rise && r_bit_cnt == 4'd7) begin
                        w_ena           = 1'b1;
                        w_read_or_write = 1'b1;
                        w_reg_addr      = r_ptr;
                        w_update_value  = {r_shift[4:0], w_sda};
                    end
                    if (w_fall && r_bit_cnt == 4'd8) begin
                        w_bit_cnt = '0;
                        w_ptr     = r_ptr + 8'd1;
                        w_sda_oe  = 1'b1;
                        w_state   = ST_WDATA_ACK;
                    end
                end
                ST_RD_FETCH: begin
                    // Strobe, let read_value settle one clk, then load it
                    w_fetch_cnt = r_fetch_cnt + 2'd1;
                    if (r_fetch_cnt == 2'd0) begin
                        w_ena           = 1'b1;
                        w_read_or_write = 1'b0;
                        w_reg_addr      = r_ptr;
                    end else if (r_fetch_cnt == 2'd2) begin
                        w_tx        = regs.read_value;
                        w_sda_oe    = ~regs.read_value[7];
                        w_bit_cnt   = '0;
                        w_fetch_cnt = '0;
                        w_state     = ST_RDATA;
                    end
                end
                ST_RDATA: if (w_fall) begin
                    if (r_bit_cnt == 4'd8) begin
                        w_bit_cnt = '0;
                        w_sda_oe  = 1'b0;
                        w_state   = ST_RDATA_ACK;
                    end else begin
                        w_tx     = {r_tx[6:0], 1'b0};
                        w_sda_oe = ~r_tx[6];
                    end
                end
                ST_RDATA_ACK: if (w_fall) begin
                    w_bit_cnt   = '0;
                    w_fetch_cnt = '0;
                    if (!r_shift[0]) begin
                        w_ptr   = r_ptr + 8'd1;
                        w_state = ST_RD_FETCH;
                    end else begin
                        w_busy  = 1'b0;
                        w_state = ST_IGNORE;
                    end
                end
                ST_IDLE, ST_IGNORE: ;
                default: w_state = ST_IDLE;
            endcase
        end
    end

    assign sda_oe             = r_sda_oe;
    assign busy               = r_busy;
    assign regs.ena           = r_ena;
    assign regs.read_or_write = r_read_or_write;
    assign regs.reg_addr      = r_reg_addr;
    assign regs.update_value  = r_update_value;
endmodule
`default_nettype wire

// File: tb/tb_i2c_target_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_frontend
// Purpose  : Bit-level I2C controller driving the target against a model.
// Revision : 1.0
// ============================================================================
module tb_i2c_target_frontend;
    import i2c_target_frontend_pkg::*;

    localparam int Q = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_drv = 1'b1;
    logic sda_oe, busy, sda_line;

    assign sda_line = sda_drv & ~sda_oe;

    i2c_target_frontend_if bus();

    i2c_target_frontend #(.DEVICE_ADDR(C_DEVICE_ADDR), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .scl_in (scl),
        .sda_in (sda_line),
        .sda_oe (sda_oe),
        .busy   (busy),
        .regs   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rf_mem [256];
    always @(posedge clk) begin
        if (rst) bus.read_value <= 8'h00;
        else if (bus.ena && !bus.read_or_write) bus.read_value <= rf_mem[bus.reg_addr];
    end

    logic [14:0] slog [1024];
    int s_wr = 0;
    int oe_total = 0;
    always @(negedge clk) begin
        if (!rst && bus.ena) begin
            slog[s_wr % 1024] <= {bus.read_or_write, bus.reg_addr, bus.update_value};
            s_wr <= s_wr + 1;
        end
        if (sda_oe) oe_total <= oe_total + 1;
    end

    int n_checks = 0;
    int n_errors = 0;
    int s_rd = 0;
    logic [7:0] m_ptr = 8'h00;
    logic [7:0] wdata [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        sda_drv = b; wait_q();
        scl = 1'b1;  wait_q();
        s = sda_line; wait_q();
        scl = 1'b0;  wait_q();
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wait_q();
        scl = 1'b1;     wait_q();
        sda_drv = 1'b0; wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_q();
        scl = 1'b1;     wait_q();
        sda_drv = 1'b1; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic last, output logic [7:0] d);
        logic s;
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, s);
            acc = {acc[6:0], s};
        end
        bit_cycle(last, s);
        d = acc;
    endtask

    task automatic expect_strobe(input string tag, input logic rw, input logic [7:0] addr,
                                 input logic [5:0] val);
        logic [14:0] e;
        check_eq({tag, "_seen"}, 32'(s_wr != s_rd), 32'd1);
        if (s_wr != s_rd) begin
            e = slog[s_rd % 1024];
            s_rd++;
            check_eq({tag, "_rw_addr"}, 32'(e[14:6]), 32'({rw, addr}));
            if (rw) check_eq({tag, "_val"}, 32'(e[5:0]), 32'(val));
        end
    endtask

    task automatic expect_no_strobe(input string tag);
        check_eq(tag, 32'(s_wr - s_rd), 32'd0);
        s_rd = s_wr;
    endtask

    // Write transaction: address, pointer, then n bytes taken from wdata
    task automatic write_txn(input logic [6:0] a, input logic [7:0] ptr, input int n,
                             input logic stop_after);
        logic ack, m;
        int oe0;
        m = (a == C_DEVICE_ADDR);
        oe0 = oe_total;
        bus_start();
        send_byte({a, 1'b0}, ack);
        check_eq("w_addr_ack", 32'(ack), 32'(m));
        send_byte(ptr, ack);
        check_eq("w_ptr_ack", 32'(ack), 32'(m));
        if (m) m_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            send_byte(wdata[i], ack);
            check_eq("w_data_ack", 32'(ack), 32'(m));
            if (m) begin
                expect_strobe("w_strobe", 1'b1, m_ptr, wdata[i][5:0]);
                m_ptr = m_ptr + 8'd1;
            end
        end
        expect_no_strobe("w_extra");
        check_eq("w_busy", 32'(busy), 32'(m));
        if (!m) check_eq("w_no_drive", 32'(oe_total - oe0), 32'd0);
        if (stop_after) begin
            bus_stop();
            check_eq("w_busy_stop", 32'(busy), 32'd0);
        end
    endtask

    // Read transaction from the current pointer; controller NACKs the last byte
    task automatic read_txn(input logic [6:0] a, input int n);
        logic ack, m;
        logic [7:0] d;
        int oe0;
        m = (a == C_DEVICE_ADDR);
        oe0 = oe_total;
        bus_start();
        send_byte({a, 1'b1}, ack);
        check_eq("r_addr_ack", 32'(ack), 32'(m));
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            if (m) begin
                expect_strobe("r_strobe", 1'b0, m_ptr, 6'd0);
                check_eq("r_data", 32'(d), 32'(rf_mem[m_ptr]));
                if (i != n - 1) m_ptr = m_ptr + 8'd1;
            end
        end
        expect_no_strobe("r_extra");
        check_eq("r_busy_nack", 32'(busy), 32'd0);
        if (!m) check_eq("r_no_drive", 32'(oe_total - oe0), 32'd0);
        bus_stop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic ack, s;
        logic [6:0] a;
        int n, oe0;

        for (int i = 0; i < 256; i++) rf_mem[i] = 8'($urandom);
        rf_mem[C_KI_ADDR] = 8'h2A;
        rf_mem[C_KD_ADDR] = 8'h00;

        repeat (5) @(negedge clk);
        check_eq("rst_hold_outputs", 32'({sda_oe, busy, bus.ena, bus.read_or_write,
                 bus.reg_addr, bus.update_value}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("reset_outputs", 32'({sda_oe, busy, bus.ena, bus.read_or_write,
                 bus.reg_addr, bus.update_value}), 32'd0);

        // Single write to K_p, top data bits discarded
        wdata[0] = 8'hD5;
        write_txn(C_DEVICE_ADDR, C_KP_ADDR, 1, 1'b1);

        // Pointer write then repeated-START read of K_i
        write_txn(C_DEVICE_ADDR, C_KI_ADDR, 0, 1'b0);
        read_txn(C_DEVICE_ADDR, 1);

        // Foreign address
        wdata[0] = 8'h3C;
        wdata[1] = 8'hC3;
        write_txn(7'h2B, 8'h40, 2, 1'b1);

        // Burst with pointer wrap
        wdata[0] = 8'h01;
        wdata[1] = 8'h02;
        wdata[2] = 8'h03;
        write_txn(C_DEVICE_ADDR, 8'hFF, 3, 1'b1);

        // STOP after four data bits, then a normal write
        bus_start();
        send_byte({C_DEVICE_ADDR, 1'b0}, ack);
        check_eq("part_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h10, ack);
        check_eq("part_ptr_ack", 32'(ack), 32'd1);
        m_ptr = 8'h10;
        for (int i = 0; i < 4; i++) bit_cycle(1'($urandom), s);
        bus_stop();
        expect_no_strobe("part_no_strobe");
        check_eq("part_oe", 32'(sda_oe), 32'd0);
        check_eq("part_busy", 32'(busy), 32'd0);
        wdata[0] = 8'($urandom);
        write_txn(C_DEVICE_ADDR, 8'h11, 1, 1'b1);

        // Randomized mix of writes, reads and pointer+read sequences
        for (int t = 0; t < 16; t++) begin
            a = ($urandom_range(3) == 0) ? 7'($urandom) : C_DEVICE_ADDR;
            n = $urandom_range(1, 3);
            for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom);
            case ($urandom_range(2))
                0: write_txn(a, 8'($urandom), n, 1'b1);
                1: read_txn(a, n);
                default: begin
                    write_txn(a, 8'($urandom), 0, 1'b0);
                    read_txn(a, n);
                end
            endcase
        end

        // Reset in the middle of a read while the target pulls SDA low
        write_txn(C_DEVICE_ADDR, C_KD_ADDR, 0, 1'b0);
        bus_start();
        send_byte({C_DEVICE_ADDR, 1'b1}, ack);
        check_eq("rst_rd_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) bit_cycle(1'b1, s);
        expect_strobe("rst_fetch", 1'b0, C_KD_ADDR, 6'd0);
        check_eq("rst_pre_oe", 32'(sda_oe), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_outputs", 32'({sda_oe, busy, bus.ena, bus.read_or_write,
                 bus.reg_addr, bus.update_value}), 32'd0);
        rst = 1'b0;
        m_ptr = 8'h00;
        oe0 = oe_total;
        sda_drv = 1'b1; wait_q();
        scl = 1'b1;     wait_q();
        check_eq("rst_released", 32'(oe_total - oe0), 32'd0);
        read_txn(C_DEVICE_ADDR, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_target_frontend.md
Name: i2c_target_frontend

Overview:
- I2C target (slave) bus front-end: synchronises raw SCL/SDA, detects START/STOP, matches a 7-bit device address, decodes transfers.
- Produces single-cycle register-access strobes (reg_addr, update_value, read_or_write, ena) for the PID gain register file directly downstream.
- Serialises that register file's read_value back onto SDA.
- Sits between the chip's open-drain pads and the gain register file.

Parameters:
- DEVICE_ADDR, 7'h2A, 7-bit I2C target address this block answers to.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 20x the SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL pad input.
- sda_in  in  1  raw SDA pad input.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- reg_addr  out  8  register pointer presented with ena.
- update_value  out  6  write data, bits [5:0] of the received data byte.
- read_or_write  out  1  1 = write strobe, 0 = read strobe; valid only while ena=1.
- ena  out  1  one-clk register-access strobe.
- read_value  in  8  register file read data; valid 1 clk after a read strobe.
- busy  out  1  1 while this target is addressed (address ACK through STOP/NACK).

Behaviour:
- Reset: all outputs 0. State is IDLE, pointer is 0x00, shift registers are cleared.
- Reset mid-transfer aborts at once and sda_oe releases in the same cycle.
- Synchronisation and edge detection:
  - SCL and SDA each pass through SYNC_STAGES FFs, then a 1-FF delay for edge detection.
  - Edges are judged on synchronised values only.
- Bus conditions:
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - Both are honoured in every state, including mid-byte. They take priority over bit sampling in the same cycle.
- Bit timing:
  - SDA is sampled on the SCL rising-edge detect, MSB first.
  - sda_oe changes only on the cycle after an SCL falling-edge detect.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RD_FETCH, RDATA, RDATA_ACK, IGNORE.
- Transitions:
  - START from any state -> ADDR (repeated START allowed). STOP -> IDLE.
  - ADDR: after 8 bits:
    - If addr[7:1] == DEVICE_ADDR -> ADDR_ACK, driving ACK (sda_oe=1) for one SCL period.
    - Otherwise -> IGNORE, with SDA never driven.
  - ADDR_ACK end (SCL falling):
    - R/W=0 -> PTR.
    - R/W=1 -> RD_FETCH.
  - PTR: 8 bits load the pointer -> PTR_ACK (ACK) -> WDATA.
  - WDATA, on the clk after the 8th rising edge:
    - ena=1, read_or_write=1, reg_addr=pointer, update_value=byte[5:0]. Bits [7:6] are discarded.
    - Then ACK -> WDATA_ACK; pointer +1 (8-bit wrap, 0xFF -> 0x00) -> WDATA.
  - RD_FETCH:
    - Pulse ena=1, read_or_write=0, reg_addr=pointer.
    - Capture read_value exactly 2 clks later into the TX shift register.
    - Drive the MSB (sda_oe = ~bit) -> RDATA. Whole fetch completes within the SCL low phase.
  - RDATA: 8 bits shifted out -> release SDA -> RDATA_ACK; sample the controller's ACK.
    - ACK (SDA low): pointer +1 -> RD_FETCH.
    - NACK: -> IGNORE until STOP/START.
  - IGNORE: sda_oe=0, no strobes.
- Strobe rules:
  - ena is high for exactly one clk per byte; never asserted in ADDR, PTR or IGNORE.
  - reg_addr, update_value and read_or_write hold their last values between strobes.
- Pointer handling:
  - The pointer is not range-checked; unknown addresses are still strobed.
  - It persists across transactions until rewritten or reset.
- busy: set at the address ACK; cleared on STOP, on a NACKed read, or on an address mismatch.

Decomposition:
- Shared package: DEVICE_ADDR default, the FSM state encoding, and the K_p/K_i/K_d register addresses 0x40/0x41/0x42 (shared with the register file and benches).
- Sub-module i2c_sync_edge: synchroniser plus rise/fall/START/STOP detector for SCL/SDA, instanced once.

Test Plan:
- Write 0x2A<<1|0, pointer 0x40, data 0xD5 -> one ena pulse with read_or_write=1, reg_addr=0x40, update_value=0x15; ACK on all 3 bytes.
- Write pointer 0x41, repeated START, 0x55 (read), master NACK -> ena with read_or_write=0, reg_addr=0x41; SDA carries read_value (e.g. 0x2A) MSB first; busy clears after NACK.
- Address 0x2B -> no ACK, sda_oe stays 0, no ena for the rest of the transfer, busy=0.
- Burst write pointer 0xFF, data 0x01,0x02,0x03 -> strobes at 0xFF, 0x00, 0x01 (wrap).
- STOP after 4 data bits of WDATA -> no ena, state IDLE, sda_oe=0; a following full write works normally.
- rst=1 for one clk mid-RDATA with sda_oe=1 -> sda_oe=0 next clk, all outputs 0, pointer 0x00.
